vote_result_announcer: RTL and testbench

Downstream consumer of the vote-logger counts in the voting machine. In result mode, a start request snapshots the four 8-bit candidate tallies and scans them sequentially to find the winner, a tie and the no-vote case. It then converts the winning count to 3-digit BCD with a serial shift-add-3 engine. The results are held for the display/LED stage, and a one-cycle done pulse marks each new result.

---
 rtl/vote_result_announcer_pkg.sv | 13 +
 rtl/vote_result_announcer_bin2bcd_seq.sv | 51 +++++
 rtl/vote_result_announcer.sv | 120 ++++++++++++
 tb/tb_vote_result_announcer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vote_result_announcer_pkg.sv
// Shared types and defaults for the vote result announcer.
package vote_result_announcer_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, CONV, DONE} state_t;

  localparam int NUM_CAND_DEF = 4;
  localparam int VOTE_W_DEF   = 8;
  localparam int ID_W         = $clog2(NUM_CAND_DEF);
  localparam int BCD_W        = 12;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/vote_result_announcer_bin2bcd_seq.sv
// Serial shift-add-3 binary to 3-digit BCD converter, one input bit per cycle, MSB first.
module bin2bcd_seq
  import vote_result_announcer_pkg::*;
#(
  parameter int VOTE_W = VOTE_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [VOTE_W-1:0] bin,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);
  localparam int SR_W  = BCD_W + VOTE_W;
  localparam int CNT_W = $clog2(VOTE_W + 1);

  logic [SR_W-1:0]  sr, adj;
  logic [CNT_W-1:0] cnt;
  logic             run;

  always_comb begin
    adj = sr;
    for (int i = 0; i < BCD_W / 4; i++)
      adj[VOTE_W + 4*i +: 4] = add3(sr[VOTE_W + 4*i +: 4]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (abort) begin
      run <= 1'b0;
    end else if (load) begin
      sr  <= {{BCD_W{1'b0}}, bin};
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      sr  <= adj << 1;
      cnt <= cnt + 1'b1;
      if (cnt == CNT_W'(VOTE_W - 1)) run <= 1'b0;
    end
  end

  // done marks the cycle whose closing edge performs the final shift
  assign busy = run;
  assign done = run && (cnt == CNT_W'(VOTE_W - 1));
  assign bcd  = sr[VOTE_W +: BCD_W];
endmodule

// File: rtl/vote_result_announcer.sv
// Snapshots candidate tallies, scans for winner/tie/no-vote, converts the winning count to BCD.
module vote_result_announcer
  import vote_result_announcer_pkg::*;
#(
  parameter  int NUM_CAND = NUM_CAND_DEF,
  parameter  int VOTE_W   = VOTE_W_DEF,
  localparam int WID_W    = $clog2(NUM_CAND)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       mode,
  input  logic                       start,
  input  logic [NUM_CAND*VOTE_W-1:0] votes,
  output logic                       busy,
  output logic                       done,
  output logic [WID_W-1:0]           winner_id,
  output logic [VOTE_W-1:0]          winner_votes,
  output logic                       tie,
  output logic                       no_votes,
  output logic [BCD_W-1:0]           bcd
);
  state_t                     state;
  logic [NUM_CAND*VOTE_W-1:0] snap;
  logic [WID_W-1:0]           idx, best_id, nbest_id;
  logic [VOTE_W-1:0]          best, cur, nbest;
  logic                       tie_w, ntie, last_idx;
  logic                       eng_load, eng_abort, eng_busy, eng_done;
  logic [BCD_W-1:0]           eng_bcd;

  assign cur      = snap[idx*VOTE_W +: VOTE_W];
  assign last_idx = (idx == WID_W'(NUM_CAND - 1));

  // Strict greater-than keeps the lowest index on equal counts
  always_comb begin
    nbest    = best;
    nbest_id = best_id;
    ntie     = tie_w;
    if (cur > best) begin
      nbest    = cur;
      nbest_id = idx;
      ntie     = 1'b0;
    end else if (cur == best && cur != '0) begin
      ntie = 1'b1;
    end
  end

  // Converter is loaded with the post-final-compare maximum on the same edge SCAN exits
  assign eng_load  = (state == SCAN) && mode && last_idx;
  assign eng_abort = (state == SCAN || state == CONV) && !mode;

  bin2bcd_seq #(.VOTE_W(VOTE_W)) u_bcd (
    .clock (clock),
    .reset (reset),
    .load  (eng_load),
    .bin   (nbest),
    .abort (eng_abort),
    .busy  (eng_busy),
    .done  (eng_done),
    .bcd   (eng_bcd)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      snap         <= '0;
      idx          <= '0;
      best         <= '0;
      best_id      <= '0;
      tie_w        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      winner_id    <= '0;
      winner_votes <= '0;
      tie          <= 1'b0;
      no_votes     <= 1'b0;
      bcd          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && mode) begin
          snap    <= votes;
          idx     <= '0;
          best    <= '0;
          best_id <= '0;
          tie_w   <= 1'b0;
          busy    <= 1'b1;
          state   <= SCAN;
        end
        SCAN: if (!mode) begin
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          best    <= nbest;
          best_id <= nbest_id;
          tie_w   <= ntie;
          idx     <= idx + 1'b1;
          if (last_idx) state <= CONV;
        end
        // An idle converter here would mean a lost load; finish rather than hang
        CONV: if (!mode) begin
          busy  <= 1'b0;
          state <= IDLE;
        end else if (eng_done || !eng_busy) begin
          state <= DONE;
        end
        DONE: begin
          done         <= 1'b1;
          winner_id    <= best_id;
          winner_votes <= best;
          bcd          <= eng_bcd;
          tie          <= tie_w;
          no_votes     <= (best == '0);
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vote_result_announcer.sv
// Randomized scoreboard bench for vote_result_announcer against an arithmetic reference model.
module tb_vote_result_announcer;
  localparam int NC = 4;
  localparam int VW = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             mode  = 1'b0;
  logic             start = 1'b0;
  logic [NC*VW-1:0] votes = '0;
  logic             busy, done, tie, no_votes;
  logic [1:0]       winner_id;
  logic [VW-1:0]    winner_votes;
  logic [11:0]      bcd;

  typedef struct {
    int          id;
    int          wv;
    bit          tie;
    bit          nov;
    logic [11:0] bcd;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t last;
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  vote_result_announcer #(.NUM_CAND(NC), .VOTE_W(VW)) dut (
    .clock        (clock),
    .reset        (reset),
    .mode         (mode),
    .start        (start),
    .votes        (votes),
    .busy         (busy),
    .done         (done),
    .winner_id    (winner_id),
    .winner_votes (winner_votes),
    .tie          (tie),
    .no_votes     (no_votes),
    .bcd          (bcd)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  function automatic exp_t model(input logic [NC*VW-1:0] v, input int due);
    exp_t e;
    int   t[NC];
    int   mx  = 0;
    int   cnt = 0;
    for (int i = 0; i < NC; i++) begin
      t[i] = int'(v[i*VW +: VW]);
      if (t[i] > mx) mx = t[i];
    end
    e.id = 0;
    for (int i = NC - 1; i >= 0; i--)
      if (t[i] == mx) begin
        e.id = i;
        cnt++;
      end
    e.wv  = mx;
    e.tie = (mx != 0) && (cnt > 1);
    e.nov = (mx == 0);
    e.bcd = {4'(mx / 100), 4'((mx / 10) % 10), 4'(mx % 10)};
    e.due = due;
    return e;
  endfunction

  task automatic chk_outputs(input string nm, input exp_t e);
    chk({nm, "_id"},   32'(winner_id),    32'(e.id));
    chk({nm, "_wv"},   32'(winner_votes), 32'(e.wv));
    chk({nm, "_tie"},  32'(tie),          32'(e.tie));
    chk({nm, "_nov"},  32'(no_votes),     32'(e.nov));
    chk({nm, "_bcd"},  32'(bcd),          32'(e.bcd));
  endtask

  // Monitor: pops an expectation on every done pulse, flags late or unexpected ones
  always @(negedge clock) begin
    if (!reset) begin
      if (q.size() > 0 && cyc > q[0].due) begin
        checks++;
        errors++;
        $display("FAIL done_late cyc=%0d actual=none required=done_at_%0d", cyc, q[0].due);
        void'(q.pop_front());
      end
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done cyc=%0d actual=done required=no_done", cyc);
        end else begin
          mon_e = q.pop_front();
          chk("latency", 32'(cyc), 32'(mon_e.due));
          chk_outputs("result", mon_e);
        end
      end
    end
  end

  // kind: 0 complete, 1 mode-drop abort, 2 reset abort; off = cycles after accept edge
  task automatic do_run(input logic [NC*VW-1:0] v, input int kind, input int off,
                        input logic [NC*VW-1:0] v_after, input bit extra);
    int   t;
    exp_t e;
    @(negedge clock);
    votes = v;
    mode  = 1'b1;
    start = 1'b1;
    t = cyc + 1;
    e = model(v, t + 13);
    if (kind == 0) q.push_back(e);
    @(negedge clock);
    start = 1'b0;
    votes = v_after;
    chk("busy_running", 32'(busy), 32'd1);
    if (kind == 0) begin
      while (cyc < t + 3) @(negedge clock);
      start = extra;
      @(negedge clock);
      start = 1'b0;
      while (cyc < t + 13) @(negedge clock);
      chk("busy_after_done", 32'(busy), 32'd0);
      last = e;
    end else begin
      while (cyc < t + off) @(negedge clock);
      if (kind == 1) mode = 1'b0;
      else           reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("busy_after_abort", 32'(busy), 32'd0);
      chk("done_after_abort", 32'(done), 32'd0);
      if (kind == 2) last = '{0, 0, 1'b0, 1'b0, 12'h000, 0};
      chk_outputs("hold", last);
      repeat (2) @(negedge clock);
      mode = 1'b1;
    end
  endtask

  function automatic logic [NC*VW-1:0] rand_votes();
    logic [NC*VW-1:0] v;
    int               sel = $urandom_range(0, 9);
    for (int i = 0; i < NC; i++)
      v[i*VW +: VW] = (sel == 0) ? 8'd0 : (sel < 5) ? 8'($urandom_range(0, 3)) : 8'($urandom);
    return v;
  endfunction

  initial begin
    last = '{0, 0, 1'b0, 1'b0, 12'h000, 0};
    repeat (3) @(negedge clock);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk_outputs("reset", last);
    reset = 1'b0;
    @(negedge clock);

    // Directed scenarios
    do_run({8'd9, 8'd3, 8'd9, 8'd5}, 0, 0, {8'd9, 8'd3, 8'd9, 8'd5}, 1'b1);
    do_run({8'd254, 8'd7, 8'd0, 8'd255}, 0, 0, {8'd255, 8'd7, 8'd0, 8'd255}, 1'b0);
    do_run('0, 0, 0, '0, 1'b0);
    @(negedge clock);
    mode  = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("mode0_start_busy", 32'(busy), 32'd0);
    repeat (15) @(negedge clock);
    do_run({8'd9, 8'd3, 8'd9, 8'd5}, 0, 0, {8'd9, 8'd3, 8'd9, 8'd5}, 1'b1);
    do_run({8'd1, 8'd2, 8'd3, 8'd100}, 1, 6, {8'd1, 8'd2, 8'd3, 8'd100}, 1'b0);
    do_run({8'd1, 8'd2, 8'd3, 8'd100}, 0, 0, {8'd1, 8'd2, 8'd3, 8'd100}, 1'b0);
    do_run({8'd50, 8'd60, 8'd70, 8'd80}, 2, 7, '0, 1'b0);
    do_run({8'd50, 8'd60, 8'd70, 8'd80}, 0, 0, '0, 1'b0);

    // Randomized runs
    for (int n = 0; n < 60; n++) begin
      int r = $urandom_range(0, 19);
      int kind = (r < 14) ? 0 : (r < 17) ? 1 : 2;
      do_run(rand_votes(), kind, (kind == 1) ? $urandom_range(0, 11) : $urandom_range(0, 12),
             rand_votes(), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    repeat (20) @(negedge clock);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
